// File: rtl/keypad_scan_if.sv
// Keypad matrix lines and debounced key events between the scanner and the note logic.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic       key_release;
  logic       key_down;
  logic [3:0] key_code;

  modport master (
    input  row_in,
    output col_out,
    output key_valid,
    output key_release,
    output key_down,
    output key_code
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_valid,
    input  key_release,
    input  key_down,
    input  key_code
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, collects a 16-bit frame,
// debounces one candidate key over whole frames and reports press/release events.
//  state    | meaning
//  IDLE     | no key held, waiting for a nonzero frame
//  DB_PRESS | candidate key seen, counting agreeing frames before accepting the press
//  PRESSED  | key accepted, key_down high
//  DB_REL   | accepted key absent, counting clean frames before reporting release
module keypad_scan #(
  parameter int SCAN_PERIOD     = 100000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input logic           clk,
  input logic           rst_n,
  keypad_scan_if.master kp
);

  localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [7:0]    CNT_LAST  = 8'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    PRESSED  = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  logic [3:0]    rs_meta;
  logic [3:0]    rs;
  logic [TW-1:0] tick_cnt;
  logic          tick_last;
  logic [1:0]    col_idx;
  logic [1:0]    col_nxt;
  logic [3:0]    col_out;
  logic [15:0]   frame;
  logic          frame_done;

  state_t      state, state_nxt;
  logic [3:0]  cand, cand_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  key_code, key_code_nxt;
  logic        key_valid, key_valid_nxt;
  logic        key_release, key_release_nxt;
  logic        key_down, key_down_nxt;
  logic [3:0]  lowest;
  logic        b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_meta <= 4'hf;
      rs      <= 4'hf;
    end else begin
      rs_meta <= kp.row_in;
      rs      <= rs_meta;
    end
  end

  assign tick_last = (tick_cnt == TICK_LAST);
  assign col_nxt   = col_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      col_idx    <= 2'd0;
      col_out    <= 4'b1110;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick_last && (col_idx == 2'd3);
      if (tick_last) begin
        tick_cnt                  <= '0;
        frame[{col_idx, 2'b00} +: 4] <= ~rs;
        col_idx                   <= col_nxt;
        col_out                   <= ~(4'b0001 << col_nxt);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  // Scan from the top so the lowest pressed code wins.
  always_comb begin
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (frame[i]) lowest = 4'(i);
    end
  end

  assign b = frame[cand];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= 4'd0;
      cnt         <= 8'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_down    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      key_code    <= key_code_nxt;
      key_valid   <= key_valid_nxt;
      key_release <= key_release_nxt;
      key_down    <= key_down_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cand_nxt        = cand;
    cnt_nxt         = cnt;
    key_code_nxt    = key_code;
    key_down_nxt    = key_down;
    key_valid_nxt   = 1'b0;
    key_release_nxt = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame != 16'd0) begin
            cand_nxt  = lowest;
            cnt_nxt   = 8'd1;
            state_nxt = DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (!b) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nxt     = PRESSED;
            key_code_nxt  = cand;
            key_valid_nxt = 1'b1;
            key_down_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        PRESSED: begin
          // Only the accepted key matters here; other keys are ignored until release.
          if (!b) begin
            cnt_nxt   = 8'd1;
            state_nxt = DB_REL;
          end
        end
        DB_REL: begin
          if (b) begin
            state_nxt = PRESSED;
          end else if (cnt == CNT_LAST) begin
            state_nxt       = IDLE;
            key_release_nxt = 1'b1;
            key_down_nxt    = 1'b0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign kp.col_out     = col_out;
  assign kp.key_valid   = key_valid;
  assign kp.key_release = key_release;
  assign kp.key_down    = key_down;
  assign kp.key_code    = key_code;

endmodule
